// File: rtl/count_wrap_monitor_pkg.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor_pkg
// Shared definitions for the up/down counter monitor and its neighbours:
//   - monitor_state_e : monitor FSM states (2-bit encoding)
//   - mode_e          : counter direction encoding, shared with counter_mod
//   - WIDTH_DEF / WRAP_W_DEF : default bus widths
//   - CNT_MAX / WRAP_MAX     : all-ones values for the default widths
// -----------------------------------------------------------------------------
package count_wrap_monitor_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int WRAP_W_DEF = 8;

    localparam int CNT_MAX  = (1 << WIDTH_DEF) - 1;
    localparam int WRAP_MAX = (1 << WRAP_W_DEF) - 1;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } monitor_state_e;

    typedef enum logic {
        MODE_UP = 1'b0,
        MODE_DN = 1'b1
    } mode_e;

endpackage

// File: rtl/count_wrap_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for statistics. Increments on inc, holds at all-ones
// once reached, and returns to zero on reset or clear.
// Ports:
//   clk   in   system clock, rising edge
//   reset in   synchronous active-high reset
//   clear in   synchronous soft clear (same effect as reset)
//   inc   in   increment request for this cycle
//   value out  registered count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (reset || clear) begin
            value <= '0;
        end else if (inc && (value != {W{1'b1}})) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// count_wrap_monitor
// Watches an up/down counter and checks that every sampled step is +/-1
// (mod 2^WIDTH) in the direction that was commanded at the previous sample.
// Reports wraps, direction changes, and latches a sticky fault on any
// illegal step (including a held count).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset (shared with the counter)
//   mode       in   counter direction, 0 = up, 1 = down
//   count      in   counter output, WIDTH bits
//   clear      in   synchronous soft clear: re-arm and zero statistics
//   locked     out  high while tracking a legal sequence
//   ovf_pulse  out  one-cycle pulse on an up-wrap (max -> 0)
//   unf_pulse  out  one-cycle pulse on a down-wrap (0 -> max)
//   dir_change out  one-cycle pulse when mode differs from the previous sample
//   wrap_count out  saturating total of wraps, WRAP_W bits
//   step_err   out  sticky illegal-step flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [WIDTH-1:0]  count,
    input  logic              clear,
    output logic              locked,
    output logic              ovf_pulse,
    output logic              unf_pulse,
    output logic              dir_change,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              step_err
);

    localparam logic [WIDTH-1:0] CNT_TOP = {WIDTH{1'b1}};

    monitor_state_e   state;
    logic [WIDTH-1:0] prev_count;
    logic             prev_mode;

    logic [WIDTH-1:0] exp_count;
    logic             step_ok;
    logic             is_ovf;
    logic             is_unf;
    logic             wrap_inc;

    // Expected value wraps naturally in WIDTH-bit arithmetic.
    always_comb begin
        // NOTE: every combinational output gets a value before any branching,
        // so no path leaves it unassigned and no latch is inferred.
        exp_count = prev_count + WIDTH'(1);
        if (prev_mode == MODE_DN) begin
            exp_count = prev_count - WIDTH'(1);
        end
        step_ok  = (count == exp_count);
        is_ovf   = step_ok && (prev_mode == MODE_UP) && (prev_count == CNT_TOP);
        is_unf   = step_ok && (prev_mode == MODE_DN) && (prev_count == '0);
        wrap_inc = (state == TRACK) && (is_ovf || is_unf);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= INIT;
            prev_count <= '0;
            prev_mode  <= MODE_UP;
            locked     <= 1'b0;
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            dir_change <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            ovf_pulse  <= 1'b0;
            unf_pulse  <= 1'b0;
            dir_change <= 1'b0;
            case (state)
                INIT: begin
                    // First sample only seeds the history; nothing to check yet.
                    prev_count <= count;
                    prev_mode  <= mode;
                    locked     <= 1'b1;
                    state      <= TRACK;
                end
                TRACK: begin
                    // Direction change is reported even on a failing step.
                    dir_change <= (mode != prev_mode);
                    if (step_ok) begin
                        prev_count <= count;
                        prev_mode  <= mode;
                        ovf_pulse  <= is_ovf;
                        unf_pulse  <= is_unf;
                    end else begin
                        step_err <= 1'b1;
                        locked   <= 1'b0;
                        state    <= FAULT;
                    end
                end
                FAULT: begin
                    // Frozen until reset or clear.
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (wrap_inc),
        .value (wrap_count)
    );

endmodule

// File: tb/tb_count_wrap_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_wrap_monitor
// Directed bench for count_wrap_monitor: drives count/mode as a counter would
// (plus deliberate illegal steps) and checks every registered output after
// each edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_count_wrap_monitor;
    import count_wrap_monitor_pkg::*;

    logic       clk;
    logic       reset;
    logic       mode;
    logic [3:0] count;
    logic       clear;
    logic       locked;
    logic       ovf_pulse;
    logic       unf_pulse;
    logic       dir_change;
    logic [7:0] wrap_count;
    logic       step_err;

    int total = 0;
    int bad   = 0;

    count_wrap_monitor #(
        .WIDTH  (4),
        .WRAP_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .count      (count),
        .clear      (clear),
        .locked     (locked),
        .ovf_pulse  (ovf_pulse),
        .unf_pulse  (unf_pulse),
        .dir_change (dir_change),
        .wrap_count (wrap_count),
        .step_err   (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check all six outputs at once.
    task automatic check_all(input string tag, input logic e_locked,
                             input logic e_ovf, input logic e_unf,
                             input logic e_dir, input logic [7:0] e_wrap,
                             input logic e_err);
        check({tag, ".locked"},     32'(locked),     32'(e_locked));
        check({tag, ".ovf_pulse"},  32'(ovf_pulse),  32'(e_ovf));
        check({tag, ".unf_pulse"},  32'(unf_pulse),  32'(e_unf));
        check({tag, ".dir_change"}, 32'(dir_change), 32'(e_dir));
        check({tag, ".wrap_count"}, 32'(wrap_count), 32'(e_wrap));
        check({tag, ".step_err"},   32'(step_err),   32'(e_err));
    endtask

    // Present count/mode, let one rising edge sample them, then settle.
    task automatic step(input logic [3:0] c, input logic m);
        count = c;
        mode  = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] cur;
        int         wraps;
        logic [7:0] exp_wrap;

        reset = 1'b1;
        clear = 1'b0;
        count = '0;
        mode  = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) step(4'd0, 1'b0);
        check_all("reset", 0, 0, 0, 0, 8'd0, 0);

        // First edge after release is the INIT capture.
        reset = 1'b0;
        step(4'd0, 1'b0);
        check_all("init_capture", 1, 0, 0, 0, 8'd0, 0);

        for (int i = 1; i <= 15; i++) step(4'(i), 1'b0);
        check_all("up_to_15", 1, 0, 0, 0, 8'd0, 0);

        step(4'd0, 1'b0);
        check_all("ovf_wrap", 1, 1, 0, 0, 8'd1, 0);
        step(4'd1, 1'b0);
        check_all("ovf_gone", 1, 0, 0, 0, 8'd1, 0);

        // Counter sees mode=1 from count=2 onward.
        step(4'd2, 1'b1);
        check_all("mode_to_dn", 1, 0, 0, 1, 8'd1, 0);
        step(4'd1, 1'b1);
        check_all("dn_1", 1, 0, 0, 0, 8'd1, 0);
        step(4'd0, 1'b1);
        check_all("dn_0", 1, 0, 0, 0, 8'd1, 0);
        step(4'(CNT_MAX), 1'b1);
        check_all("unf_wrap", 1, 0, 1, 0, 8'd2, 0);
        step(4'd14, 1'b1);
        check_all("unf_gone", 1, 0, 0, 0, 8'd2, 0);

        // Back to up: the step is still a down step, direction flag pulses.
        step(4'd13, 1'b0);
        check_all("mode_to_up", 1, 0, 0, 1, 8'd2, 0);
        step(4'd14, 1'b0);
        step(4'd15, 1'b0);
        step(4'd0, 1'b0);
        check_all("ovf_wrap2", 1, 1, 0, 0, 8'd3, 0);
        for (int i = 1; i <= 5; i++) step(4'(i), 1'b0);
        check_all("up_to_5", 1, 0, 0, 0, 8'd3, 0);

        // Illegal jump 5 -> 7.
        step(4'd7, 1'b0);
        check_all("jump_fault", 0, 0, 0, 0, 8'd3, 1);
        for (int i = 8; i <= 15; i++) step(4'(i), 1'b0);
        step(4'd0, 1'b0);
        check_all("fault_frozen_wrap", 0, 0, 0, 0, 8'd3, 1);
        step(4'd1, 1'b1);
        check_all("fault_frozen_dir", 0, 0, 0, 0, 8'd3, 1);

        // Soft clear re-arms.
        clear = 1'b1;
        step(4'd1, 1'b0);
        check_all("clear", 0, 0, 0, 0, 8'd0, 0);
        clear = 1'b0;
        step(4'd2, 1'b0);
        check_all("rearm_capture", 1, 0, 0, 0, 8'd0, 0);
        step(4'd2, 1'b0);
        check_all("hold_is_fault", 0, 0, 0, 0, 8'd0, 1);

        clear = 1'b1;
        step(4'd2, 1'b0);
        clear = 1'b0;
        step(4'd3, 1'b0);
        check_all("rearm2", 1, 0, 0, 0, 8'd0, 0);

        // Free run: 300 up-wraps, wrap_count must stick at all-ones.
        cur   = 4'd3;
        wraps = 0;
        while (wraps < 300) begin
            cur = cur + 4'd1;
            step(cur, 1'b0);
            if (cur == 4'd0) begin
                wraps++;
                exp_wrap = (wraps > WRAP_MAX) ? 8'(WRAP_MAX) : 8'(wraps);
                check_all($sformatf("free_wrap%0d", wraps), 1, 1, 0, 0, exp_wrap, 0);
            end else if (cur == 4'd1) begin
                check("free_nowrap.ovf_pulse", 32'(ovf_pulse), 32'd0);
            end
        end
        check("saturated", 32'(wrap_count), 32'(WRAP_MAX));

        // Run up to 9, then reset and clear together.
        for (int i = 1; i <= 9; i++) step(4'(i), 1'b0);
        check_all("at_9", 1, 0, 0, 0, 8'(WRAP_MAX), 0);
        reset = 1'b1;
        clear = 1'b1;
        step(4'd9, 1'b0);
        check_all("reset_and_clear", 0, 0, 0, 0, 8'd0, 0);
        reset = 1'b0;
        clear = 1'b0;
        step(4'd0, 1'b0);
        check_all("resume_capture", 1, 0, 0, 0, 8'd0, 0);
        step(4'd1, 1'b0);
        step(4'd2, 1'b0);
        check_all("resume_track", 1, 0, 0, 0, 8'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
